load_byte_sequencer: RTL and testbench
======================================

LOAD_BYTE_SEQUENCER -- requirements
Module: load_byte_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of request and memory byte addresses.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have req_valid  in  1  load request present.
REQ-004 SHALL have req_ready  out  1  request accepted when high with req_valid.
REQ-005 SHALL have req_addr  in  ADDR_W  byte address of load.
REQ-006 SHALL have req_funct3  in  3  RV32I load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 SHALL have mem_rd_en  out  1  byte read strobe.
REQ-008 SHALL have mem_addr  out  ADDR_W  byte address of read.
REQ-009 SHALL have mem_rdata  in  8  read byte, valid exactly one cycle after mem_rd_en.
REQ-010 SHALL have rsp_valid  out  1  result available.
REQ-011 SHALL have rsp_ready  in  1  consumer takes result.
REQ-012 SHALL have rsp_data  out  32  extended load result.
REQ-013 SHALL have rsp_err  out  1  misaligned address or illegal funct3.

Function
REQ-014 SHALL use states IDLE, READ, DRAIN, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid&&req_ready.
REQ-016 SHALL set byte count N: 1 for LB/LBU, 2 for LH/LHU, 4 for LW.
REQ-017 SHALL flag an error when funct3 is 011/110/111, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=00; on error go IDLE->RESP directly, issue no memory read, rsp_data=0, rsp_err=1.
REQ-018 SHALL, for a legal request, go IDLE->READ and issue mem_rd_en=1 on N consecutive cycles with mem_addr=req_addr+i, i=0..N-1; no gaps.
REQ-019 SHALL capture mem_rdata one cycle after each strobe into byte lane i (little-endian: lane 0 = bits 7:0).
REQ-020 SHALL go READ->DRAIN after the last strobe, DRAIN->RESP after the last byte is captured.
REQ-021 SHALL, in RESP, hold rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-022 SHALL assert rsp_valid at cycle T+N+2 for a legal request accepted at edge T, and at T+1 for an error request.
REQ-023 SHALL sign-extend bit 7 (LB) or bit 15 (LH) and zero-extend for LBU/LHU into 32 bits; LW passes all 32 bits.
REQ-024 SHALL compute mem_addr modulo 2^ADDR_W (address wrap at top of space allowed, no error).
REQ-025 SHALL keep mem_rd_en=0 in IDLE, DRAIN and RESP.
REQ-026 SHALL ignore req_valid outside IDLE; new request accepted no earlier than the cycle after the RESP handshake.
REQ-027 SHALL clear rsp_err to 0 on every legal response.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, enter IDLE and drive req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, byte counters and capture lanes 0.
REQ-029 SHALL abandon any in-flight load on reset mid-operation; mem_rdata returned after reset is discarded and no response is produced.

Structure
REQ-030 SHALL place funct3 load encodings, state enum and byte-count constants in shared package rv32_load_pkg.
REQ-031 SHALL instantiate one combinational sub-module load_extend (32-bit raw + funct3 -> extended 32-bit result); all sequencing stays in load_byte_sequencer.

Verification
REQ-032 SHALL cover LB at addr 0x103, mem byte 0x80 -> rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid at T+3.
REQ-033 SHALL cover LBU at 0x103, byte 0x80 -> rsp_data=0x00000080.
REQ-034 SHALL cover LW at 0x200, bytes 0x78,0x56,0x34,0x12 -> mem_addr 0x200..0x203 on 4 consecutive cycles, rsp_data=0x12345678 at T+6.
REQ-035 SHALL cover LH at 0x201 and funct3=011 at 0x200 -> no mem_rd_en, rsp_err=1, rsp_data=0, rsp_valid at T+1.
REQ-036 SHALL cover LHU at 0x10 bytes 0x34,0xF2 with rsp_ready held 0 for 3 cycles -> rsp_data=0x0000F234 stable, req_ready=0 until handshake.
REQ-037 SHALL cover rst_n=0 during LW READ -> next cycle IDLE, all outputs reset values, no response emitted.

Source files
------------

// File: rtl/rv32_load_pkg.sv
// ---------------------------------------------------------------------------
// rv32_load_pkg
// Shared definitions for the byte-serial RV32I load path:
//   - funct3 encodings of the five legal load types
//   - sequencer state encodings
//   - byte-count constants and small decode helpers
// ---------------------------------------------------------------------------
package rv32_load_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t RESP  = 2'd3;

    // Number of bytes fetched per load type
    localparam logic [2:0] NBYTES_BYTE = 3'd1;
    localparam logic [2:0] NBYTES_HALF = 3'd2;
    localparam logic [2:0] NBYTES_WORD = 3'd4;

    function automatic logic [2:0] load_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_LH, F3_LHU: return NBYTES_HALF;
            F3_LW:         return NBYTES_WORD;
            default:       return NBYTES_BYTE;
        endcase
    endfunction

    // High for an undefined funct3 or an address not aligned to the access size.
    function automatic logic load_err(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr_lo[0];
            F3_LW:         return addr_lo != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of an assembled little-endian load value.
// Ports:
//   raw     in  32  assembled bytes, lane 0 in bits 7:0
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   result  out 32  extended result, 0 for an undefined funct3
// ---------------------------------------------------------------------------
module load_extend
    import rv32_load_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    always_comb begin
        // NOTE: default assignment first so every path drives result (no latch).
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   result = raw;
            F3_LBU:  result = {24'h0, raw[7:0]};
            F3_LHU:  result = {16'h0, raw[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_byte_sequencer.sv
// ---------------------------------------------------------------------------
// load_byte_sequencer
// Turns one RV32I load request into 1, 2 or 4 back-to-back byte reads on an
// 8-bit memory port with one cycle of read latency, assembles the bytes
// little-endian and returns the sign/zero-extended result.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_addr, req_funct3       byte address and load type
//   mem_rd_en, mem_addr        byte read strobe and address
//   mem_rdata                  read byte, valid the cycle after the strobe
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          extended result, misalignment/illegal flag
// ---------------------------------------------------------------------------
module load_byte_sequencer
    import rv32_load_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    state_t      state;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic [1:0]  last_idx;   // N-1 for the load in flight
    logic [1:0]  rd_cnt;     // index of the strobe currently on the port
    logic [1:0]  cap_cnt;    // lane the next returning byte lands in
    logic        cap_en;     // a requested byte is on mem_rdata this cycle
    logic [31:0] raw;
    logic [31:0] ext;

    logic [2:0]  req_n;
    logic        req_bad;

    assign req_n   = load_bytes(req_funct3);
    assign req_bad = load_err(req_funct3, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: capture lanes and counters are ordinary flops and are cleared
            // here, so an interrupted load leaves nothing behind.
            state     <= IDLE;
            funct3_q  <= '0;
            err_q     <= 1'b0;
            last_idx  <= '0;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            cap_en    <= 1'b0;
            raw       <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every flop sees pre-edge values.
            // Byte return trails the strobe by exactly one cycle.
            cap_en <= mem_rd_en;
            if (cap_en) begin
                raw[{cap_cnt, 3'b000} +: 8] <= mem_rdata;
                cap_cnt                     <= cap_cnt + 2'd1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        err_q    <= req_bad;
                        last_idx <= 2'(req_n - 3'd1);
                        rd_cnt   <= '0;
                        cap_cnt  <= '0;
                        raw      <= '0;
                        if (req_bad) begin
                            state <= RESP;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= req_addr;
                        end
                    end
                end
                READ: begin
                    if (rd_cnt == last_idx) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        rd_cnt   <= rd_cnt + 2'd1;
                        // Wraps naturally at the top of the address space.
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (cap_en && (cap_cnt == last_idx)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    load_extend u_extend (
        .raw    (raw),
        .funct3 (funct3_q),
        .result (ext)
    );

    // Outputs decode from registered state, so they stay stable while RESP waits.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_data  = ((state == RESP) && !err_q) ? ext : 32'h0;

endmodule

// File: tb/tb_load_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_load_byte_sequencer
// Table-driven bench for load_byte_sequencer with a one-cycle-latency byte
// memory responder, a strobe monitor and an expected-response queue.
// Cycle numbering: if a request is accepted on edge T, a signal first seen
// after edge T+k is "at T+k+1".
// ---------------------------------------------------------------------------
module tb_load_byte_sequencer;
    import rv32_load_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    load_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: four bytes starting at mem_base, returned one cycle
    // after the strobe that requested them.
    logic [ADDR_W-1:0] mem_base;
    logic [7:0]        mem_bytes [4];
    logic              resp_hit;
    logic [ADDR_W-1:0] resp_addr;

    always @(posedge clk) begin
        resp_hit  = mem_rd_en;
        resp_addr = mem_addr;
        #1;
        mem_rdata = resp_hit ? mem_bytes[2'(resp_addr - mem_base)] : 8'hEE;
    end

    // Strobe monitor
    logic [ADDR_W-1:0] strobe_addr_q [$];
    int                strobe_cyc_q  [$];

    always @(negedge clk) begin
        if (mem_rd_en) begin
            strobe_addr_q.push_back(mem_addr);
            strobe_cyc_q.push_back(cyc);
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q [$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        f3;
        logic [31:0]       word;       // memory bytes, lane 0 in bits 7:0
        int                stall;      // cycles rsp_ready held low
        logic              hold_valid; // keep req_valid high while busy
        int                exp_n;      // expected strobes (0 on error)
        logic [31:0]       exp_data;
        logic              exp_err;
    } vec_t;

    vec_t vecs [$];

    // Called on a negedge with the DUT idle; returns on a negedge.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   t_acc;
        int   waited;
        strobe_addr_q.delete();
        strobe_cyc_q.delete();
        mem_base = v.addr;
        for (int i = 0; i < 4; i++) mem_bytes[i] = v.word[8*i +: 8];

        check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        sb_q.push_back('{data: v.exp_data, err: v.exp_err,
                         lat: v.exp_err ? 0 : v.exp_n + 1});
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        if (v.hold_valid) begin
            // A different request left pending while busy must be ignored.
            req_addr   = v.addr ^ 32'h40;
            req_funct3 = F3_LW;
        end else begin
            req_valid = 1'b0;
        end

        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        e = sb_q.pop_front();
        if (!rsp_valid) begin
            check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(cyc - t_acc), 32'(e.lat));
            check({tag, "_data"}, rsp_data, e.data);
            check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, "_stall_data"}, rsp_data, e.data);
                check({tag, "_stall_req_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
            check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
        end

        check({tag, "_strobe_count"}, 32'(strobe_addr_q.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < strobe_addr_q.size(); i++) begin
            check({tag, "_strobe_addr"}, strobe_addr_q[i], v.addr + ADDR_W'(i));
            check({tag, "_strobe_cycle"}, 32'(strobe_cyc_q[i] - t_acc), 32'(i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [31:0] r;
        logic [31:0] w;
        vec_t        v;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        rsp_ready  = 1'b0;
        mem_rdata  = 8'h00;
        mem_base   = '0;
        for (int i = 0; i < 4; i++) mem_bytes[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        //             addr          f3      word          stall hold n  exp_data      err
        vecs.push_back('{32'h0000_0103, F3_LB,  32'h0000_0080, 0, 1'b0, 1, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{32'h0000_0103, F3_LBU, 32'h0000_0080, 0, 1'b0, 1, 32'h0000_0080, 1'b0});
        vecs.push_back('{32'h0000_0200, F3_LW,  32'h1234_5678, 0, 1'b0, 4, 32'h1234_5678, 1'b0});
        vecs.push_back('{32'h0000_0201, F3_LH,  32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0200, 3'b011, 32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0010, F3_LHU, 32'h0000_F234, 3, 1'b1, 2, 32'h0000_F234, 1'b0});
        vecs.push_back('{32'h0000_0022, F3_LH,  32'h0000_8001, 0, 1'b0, 2, 32'hFFFF_8001, 1'b0});
        vecs.push_back('{32'h0000_0022, F3_LH,  32'h0000_7FFE, 0, 1'b0, 2, 32'h0000_7FFE, 1'b0});
        vecs.push_back('{32'h0000_0005, F3_LB,  32'h0000_007F, 0, 1'b0, 1, 32'h0000_007F, 1'b0});
        vecs.push_back('{32'h0000_0040, F3_LHU, 32'h0000_8000, 1, 1'b0, 2, 32'h0000_8000, 1'b0});
        vecs.push_back('{32'hFFFF_FFFC, F3_LW,  32'hDEAD_BEEF, 2, 1'b1, 4, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, F3_LBU, 32'h0000_00C3, 0, 1'b0, 1, 32'h0000_00C3, 1'b0});
        vecs.push_back('{32'h0000_0000, 3'b110, 32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0004, 3'b111, 32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0202, F3_LW,  32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0031, F3_LHU, 32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0301, F3_LW,  32'hAAAA_AAAA, 0, 1'b0, 0, 32'h0000_0000, 1'b1});

        foreach (vecs[k]) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // A few random aligned words: the result is the memory word itself.
        for (int k = 0; k < 4; k++) begin
            r = $urandom();
            w = $urandom();
            v = '{{r[31:2], 2'b00}, F3_LW, w, k % 2, 1'b0, 4, w, 1'b0};
            run_vec(v, $sformatf("rand_lw%0d", k));
        end

        // Reset in the middle of an LW read burst.
        strobe_addr_q.delete();
        strobe_cyc_q.delete();
        mem_base = 32'h0000_0300;
        for (int i = 0; i < 4; i++) mem_bytes[i] = 8'h91 + 8'(i);
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0300;
        req_funct3 = F3_LW;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midreset_in_read", 32'(mem_rd_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        strobe_addr_q.delete();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("midreset_no_response", 32'(seen), 32'd0);
        check("midreset_no_strobes", 32'(strobe_addr_q.size()), 32'd0);

        // Next load after the abandoned one must be clean.
        v = '{32'h0000_0306, F3_LH, 32'h0000_A55A, 0, 1'b0, 2, 32'hFFFF_A55A, 1'b0};
        run_vec(v, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
